// File: rtl/gps_nmea_pkg.sv
// gps_nmea_pkg: parser state type, NMEA ASCII constants, sentence length limit
// and character-class helpers shared by the gps_nmea_rx slice.
package gps_nmea_pkg;

  typedef enum logic [2:0] {
    P_IDLE   = 3'd0,
    P_HDR    = 3'd1,
    P_FIELDS = 3'd2,
    P_CHK_HI = 3'd3,
    P_CHK_LO = 3'd4
  } parse_state_t;

  localparam logic [7:0] ASCII_DOLLAR = 8'h24;
  localparam logic [7:0] ASCII_STAR   = 8'h2A;
  localparam logic [7:0] ASCII_COMMA  = 8'h2C;
  localparam logic [7:0] ASCII_A      = 8'h41;
  localparam logic [7:0] ASCII_V      = 8'h56;
  localparam logic [7:0] ASCII_G      = 8'h47;
  localparam logic [7:0] ASCII_R      = 8'h52;
  localparam logic [7:0] ASCII_M      = 8'h4D;
  localparam logic [7:0] ASCII_C      = 8'h43;

  localparam int NMEA_MAX_LEN = 82;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  // Uppercase hex digits only; lowercase is not a legal NMEA checksum.
  function automatic logic is_hex_upper(input logic [7:0] c);
    return ((c >= 8'h30) && (c <= 8'h39)) || ((c >= 8'h41) && (c <= 8'h46));
  endfunction

  // Returns 0 for characters that are not uppercase hex digits.
  function automatic logic [3:0] hex_to_nibble(input logic [7:0] c);
    logic [3:0] n;
    if ((c >= 8'h30) && (c <= 8'h39)) begin
      n = c[3:0];
    end else if ((c >= 8'h41) && (c <= 8'h46)) begin
      n = c[3:0] + 4'd9;
    end else begin
      n = 4'd0;
    end
    return n;
  endfunction

  // Header pattern after '$': G, any talker char, R, M, C.
  function automatic logic hdr_char_ok(input logic [2:0] idx, input logic [7:0] c);
    logic ok;
    case (idx)
      3'd0:    ok = (c == ASCII_G);
      3'd1:    ok = 1'b1;
      3'd2:    ok = (c == ASCII_R);
      3'd3:    ok = (c == ASCII_M);
      3'd4:    ok = (c == ASCII_C);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1: 2-FF synchronizer, start validation at half a bit period,
// LSB-first 8-bit capture and stop-bit framing check.
module uart_rx_8n1 #(
  parameter int CLK_HZ = 10_000_000,
  parameter int BAUD   = 9600
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err
);

  localparam int DIV  = CLK_HZ / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV + 1);

  typedef enum logic [2:0] {
    U_IDLE  = 3'd0,
    U_START = 3'd1,
    U_DATA  = 3'd2,
    U_STOP  = 3'd3,
    U_WAIT  = 3'd4
  } uart_state_t;

  uart_state_t   r_state;
  uart_state_t   w_next_state;
  logic [1:0]    r_sync;
  logic          r_rx_d;
  logic          w_rx;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_frame_err;
  logic          w_tick;
  logic          w_shift_en;
  logic          w_byte_ok;
  logic          w_byte_bad;

  assign w_rx      = r_sync[1];
  assign data      = r_data;
  assign valid     = r_valid;
  assign frame_err = r_frame_err;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= U_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state: start edge, false-start rejection, bit count, stop check, re-arm on high
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      U_IDLE: begin
        if (r_rx_d && !w_rx) w_next_state = U_START;
        else                 w_next_state = U_IDLE;
      end
      U_START: begin
        if (w_tick) w_next_state = w_rx ? U_IDLE : U_DATA;
        else        w_next_state = U_START;
      end
      U_DATA: begin
        if (w_tick && (r_bit == 3'd7)) w_next_state = U_STOP;
        else                           w_next_state = U_DATA;
      end
      U_STOP: begin
        if (w_tick) w_next_state = w_rx ? U_IDLE : U_WAIT;
        else        w_next_state = U_STOP;
      end
      U_WAIT: begin
        if (w_rx) w_next_state = U_IDLE;
        else      w_next_state = U_WAIT;
      end
      default: w_next_state = U_IDLE;
    endcase
  end

  // Output decode: sample ticks and byte outcome
  always_comb begin
    if (r_state == U_START) begin
      w_tick = (r_cnt == CW'(HALF - 1));
    end else begin
      w_tick = (r_cnt == CW'(DIV - 1));
    end
    w_shift_en = (r_state == U_DATA) && w_tick;
    w_byte_ok  = (r_state == U_STOP) && w_tick && w_rx;
    w_byte_bad = (r_state == U_STOP) && w_tick && !w_rx;
  end

  // Synchronizer, bit timer, shift register and registered byte outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync      <= 2'b11;
      r_rx_d      <= 1'b1;
      r_cnt       <= {CW{1'b0}};
      r_bit       <= 3'd0;
      r_shift     <= 8'h00;
      r_data      <= 8'h00;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_sync      <= {r_sync[0], i_rx};
      r_rx_d      <= w_rx;
      r_valid     <= w_byte_ok;
      r_frame_err <= w_byte_bad;
      if ((w_next_state != r_state) || w_tick || (r_state == U_IDLE) || (r_state == U_WAIT)) begin
        r_cnt <= {CW{1'b0}};
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (r_state == U_IDLE) begin
        r_bit <= 3'd0;
      end else if (w_shift_en) begin
        r_bit   <= r_bit + 3'd1;
        r_shift <= {w_rx, r_shift[7:1]};
      end
      if (w_byte_ok) begin
        r_data <= r_shift;
      end
    end
  end

endmodule

// File: rtl/gps_nmea_rx.sv
// gps_nmea_rx: GPS UART receiver plus $xxRMC parser publishing UTC time,
// per-sentence strobes and a timeout-qualified lock flag.
// Optional feature macro: GPS_NMEA_CHECKSUM_EN (checksum comparison; when
// undefined the checksum characters are consumed but not checked).
module gps_nmea_rx #(
  parameter int CLK_HZ         = 10_000_000,
  parameter int BAUD           = 9600,
  parameter int LOCK_TIMEOUT_S = 3
) (
  input  logic        CLOCK_10M,
  input  logic        RESET,
  input  logic        GPS_TX,
  output logic        GPS_LOCK,
  output logic [23:0] UTC_BCD,
  output logic        RMC_VALID,
  output logic        RX_ERR
);
  import gps_nmea_pkg::*;

  localparam int LOCK_TICKS = LOCK_TIMEOUT_S * CLK_HZ;
  localparam int LW         = $clog2(LOCK_TICKS + 1);

  logic [7:0]   w_byte;
  logic         w_bv;
  logic         w_frame_err;
  parse_state_t r_state;
  parse_state_t w_next_state;
  logic [6:0]   r_len;
  logic [6:0]   w_len_inc;
  logic [2:0]   r_hdr_idx;
  logic [3:0]   r_field;
  logic [2:0]   r_fchar;
  logic [23:0]  r_utc_sh;
  logic         r_stat_sh;
  logic [23:0]  r_utc;
  logic         r_stat_a;
  logic [LW-1:0] r_lock_cnt;
  logic         r_lock;
  logic         r_rmc_valid;
  logic         r_rx_err;
  logic         w_is_dollar;
  logic         w_len_over;
  logic         w_digit;
  logic         w_hex_ok;
  logic         w_field_abort;
  logic         w_star_ok;
  logic         w_chk_ok;
  logic         w_commit;
  logic         w_err;
  logic         w_stat_next;
  logic [LW-1:0] w_cnt_next;
  logic         w_lock_next;

  uart_rx_8n1 #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_uart (
    .i_clk     (CLOCK_10M),
    .i_rst     (RESET),
    .i_rx      (GPS_TX),
    .data      (w_byte),
    .valid     (w_bv),
    .frame_err (w_frame_err)
  );

  assign GPS_LOCK  = r_lock;
  assign UTC_BCD   = r_utc;
  assign RMC_VALID = r_rmc_valid;
  assign RX_ERR    = r_rx_err;

  assign w_is_dollar   = (w_byte == ASCII_DOLLAR);
  assign w_len_inc     = r_len + 7'd1;
  assign w_len_over    = (r_state != P_IDLE) && (w_len_inc > 7'(NMEA_MAX_LEN));
  assign w_digit       = is_digit(w_byte);
  assign w_hex_ok      = is_hex_upper(w_byte);
  // Field 1 needs six digits before anything else; field 2 needs A or V first.
  assign w_field_abort = ((r_field == 4'd1) && (r_fchar < 3'd6) && !w_digit) ||
                         ((r_field == 4'd2) && (r_fchar == 3'd0) &&
                          (w_byte != ASCII_A) && (w_byte != ASCII_V));
  // '*' is only meaningful once the status character has been captured.
  assign w_star_ok     = (r_field > 4'd2) || ((r_field == 4'd2) && (r_fchar != 3'd0));

`ifdef GPS_NMEA_CHECKSUM_EN
  logic [7:0] r_acc;
  logic [3:0] r_chk_hi;

  // XOR accumulator over the sentence body and latch of the high checksum nibble
  always_ff @(posedge CLOCK_10M) begin
    if (RESET) begin
      r_acc    <= 8'h00;
      r_chk_hi <= 4'h0;
    end else if (w_bv) begin
      if (w_is_dollar) begin
        r_acc <= 8'h00;
      end else if (((r_state == P_HDR) || (r_state == P_FIELDS)) && (w_byte != ASCII_STAR)) begin
        r_acc <= r_acc ^ w_byte;
      end
      if (r_state == P_CHK_HI) begin
        r_chk_hi <= hex_to_nibble(w_byte);
      end
    end
  end

  assign w_chk_ok = ({r_chk_hi, hex_to_nibble(w_byte)} == r_acc);
`else
  assign w_chk_ok = 1'b1;
`endif

  // Parser state register
  always_ff @(posedge CLOCK_10M) begin
    if (RESET) begin
      r_state <= P_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Parser next-state: '$' always restarts, overlong aborts, otherwise per-state rules
  always_comb begin
    w_next_state = r_state;
    if (!w_bv) begin
      w_next_state = r_state;
    end else if (w_is_dollar) begin
      w_next_state = P_HDR;
    end else if (w_len_over) begin
      w_next_state = P_IDLE;
    end else begin
      case (r_state)
        P_IDLE: w_next_state = P_IDLE;
        P_HDR: begin
          if (!hdr_char_ok(r_hdr_idx, w_byte)) w_next_state = P_IDLE;
          else if (r_hdr_idx == 3'd4)          w_next_state = P_FIELDS;
          else                                 w_next_state = P_HDR;
        end
        P_FIELDS: begin
          if (w_byte == ASCII_STAR) w_next_state = w_star_ok ? P_CHK_HI : P_IDLE;
          else if (w_field_abort)   w_next_state = P_IDLE;
          else                      w_next_state = P_FIELDS;
        end
        P_CHK_HI: w_next_state = w_hex_ok ? P_CHK_LO : P_IDLE;
        P_CHK_LO: w_next_state = P_IDLE;
        default:  w_next_state = P_IDLE;
      endcase
    end
  end

  // Parser outputs: commit/error decisions and next lock-timer values
  always_comb begin
    w_commit = w_bv && !w_is_dollar && !w_len_over && (r_state == P_CHK_LO) && w_hex_ok && w_chk_ok;
    w_err    = w_frame_err ||
               (w_bv && !w_is_dollar &&
                (w_len_over || ((r_state == P_CHK_LO) && w_hex_ok && !w_chk_ok)));
    if (w_commit) begin
      w_stat_next = r_stat_sh;
    end else begin
      w_stat_next = r_stat_a;
    end
    if (w_commit && r_stat_sh) begin
      w_cnt_next = LW'(LOCK_TICKS);
    end else if (r_lock_cnt != {LW{1'b0}}) begin
      w_cnt_next = r_lock_cnt - LW'(1);
    end else begin
      w_cnt_next = {LW{1'b0}};
    end
    w_lock_next = w_stat_next && (w_cnt_next != {LW{1'b0}});
  end

  // Sentence counters, UTC/status shadows, published outputs and lock timer
  always_ff @(posedge CLOCK_10M) begin
    if (RESET) begin
      r_len       <= 7'd0;
      r_hdr_idx   <= 3'd0;
      r_field     <= 4'd0;
      r_fchar     <= 3'd0;
      r_utc_sh    <= 24'h000000;
      r_stat_sh   <= 1'b0;
      r_utc       <= 24'h000000;
      r_stat_a    <= 1'b0;
      r_lock_cnt  <= {LW{1'b0}};
      r_lock      <= 1'b0;
      r_rmc_valid <= 1'b0;
      r_rx_err    <= 1'b0;
    end else begin
      r_rmc_valid <= w_commit;
      r_rx_err    <= w_err;
      r_stat_a    <= w_stat_next;
      r_lock_cnt  <= w_cnt_next;
      r_lock      <= w_lock_next;
      if (w_commit) begin
        r_utc <= r_utc_sh;
      end
      if (w_bv) begin
        if (w_is_dollar) begin
          r_len     <= 7'd1;
          r_hdr_idx <= 3'd0;
          r_field   <= 4'd0;
          r_fchar   <= 3'd0;
        end else if (r_state != P_IDLE) begin
          r_len <= w_len_inc;
          if (r_state == P_HDR) begin
            r_hdr_idx <= r_hdr_idx + 3'd1;
          end
          if (r_state == P_FIELDS) begin
            if (w_byte == ASCII_COMMA) begin
              if (r_field != 4'hF) begin
                r_field <= r_field + 4'd1;
              end
              r_fchar <= 3'd0;
            end else begin
              // Six digits shifted in leave hh at the top nibbles.
              if ((r_field == 4'd1) && (r_fchar < 3'd6) && w_digit) begin
                r_utc_sh <= {r_utc_sh[19:0], w_byte[3:0]};
              end
              if ((r_field == 4'd2) && (r_fchar == 3'd0)) begin
                r_stat_sh <= (w_byte == ASCII_A);
              end
              if (r_fchar != 3'd7) begin
                r_fchar <= r_fchar + 3'd1;
              end
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_gps_nmea_rx.sv
// tb_gps_nmea_rx: directed sentences over a scaled UART (4 clocks per bit,
// 8000-cycle lock timeout) with hand-computed expectations.
module tb_gps_nmea_rx;

  localparam int CLK_HZ     = 8000;
  localparam int BAUD       = 2000;
  localparam int DIV        = CLK_HZ / BAUD;
  localparam int LOCK_TICKS = 8000;

  logic        clk;
  logic        rst;
  logic        tx;
  logic        gps_lock;
  logic [23:0] utc_bcd;
  logic        rmc_valid;
  logic        rx_err;

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;
  int n_valid  = 0;
  int n_err    = 0;
  int t_commit = 0;
  int t_fall   = 0;
  logic lock_q = 1'b0;
  int v0;
  int e0;

  gps_nmea_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .LOCK_TIMEOUT_S(1)) dut (
    .CLOCK_10M (clk),
    .RESET     (rst),
    .GPS_TX    (tx),
    .GPS_LOCK  (gps_lock),
    .UTC_BCD   (utc_bcd),
    .RMC_VALID (rmc_valid),
    .RX_ERR    (rx_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event monitor: pulse counts, commit time and lock fall time
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rmc_valid === 1'b1) begin
      n_valid  <= n_valid + 1;
      t_commit <= cyc;
    end
    if (rx_err === 1'b1) n_err <= n_err + 1;
    if (lock_q && (gps_lock === 1'b0)) t_fall <= cyc;
    lock_q <= (gps_lock === 1'b1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    tx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      tx = b[i];
      repeat (DIV) @(negedge clk);
    end
    tx = stop_bit;
    repeat (DIV) @(negedge clk);
    tx = 1'b1;
    if (!stop_bit) repeat (3 * DIV) @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  // '$' + body + '*' + checksum (XOR-ed with flip) + CR LF
  task automatic send_sentence(input string body, input logic [7:0] flip);
    logic [7:0] x;
    x = 8'h00;
    send_byte(8'h24, 1'b1);
    for (int i = 0; i < body.len(); i++) begin
      x = x ^ body[i];
      send_byte(body[i], 1'b1);
    end
    x = x ^ flip;
    send_byte(8'h2A, 1'b1);
    send_byte(hexc(x[7:4]), 1'b1);
    send_byte(hexc(x[3:0]), 1'b1);
    send_byte(8'h0D, 1'b1);
    send_byte(8'h0A, 1'b1);
  endtask

  task automatic snap();
    v0 = n_valid;
    e0 = n_err;
  endtask

  task automatic settle();
    repeat (3 * DIV) @(negedge clk);
  endtask

  initial begin
    string body;
    rst = 1'b1;
    tx  = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("reset_lock", gps_lock, 0);
    check_eq("reset_utc", utc_bcd, 24'h000000);
    check_eq("reset_rmc_valid", rmc_valid, 0);
    check_eq("reset_rx_err", rx_err, 0);

    // Reference sentence, status A
    snap();
    send_str("$GPRMC,123519,A,4807.038,N,01131.000,E,022.4,084.4,230394,003.1,W*6A\r\n");
    settle();
    check_eq("a_commit_count", n_valid - v0, 1);
    check_eq("a_err_count", n_err - e0, 0);
    check_eq("a_utc", utc_bcd, 24'h123519);
    check_eq("a_lock", gps_lock, 1);

    // Status V drops lock
    snap();
    send_str("$GPRMC,123519,V,4807.038,N,01131.000,E,022.4,084.4,230394,003.1,W*7D\r\n");
    settle();
    check_eq("v_commit_count", n_valid - v0, 1);
    check_eq("v_lock", gps_lock, 0);
    check_eq("v_utc", utc_bcd, 24'h123519);

    // New time, status A, bench-computed checksum
    snap();
    send_sentence("GPRMC,235959,A,4807.038,N,01131.000,E,022.4,084.4,230394,003.1,W", 8'h00);
    settle();
    check_eq("a2_commit_count", n_valid - v0, 1);
    check_eq("a2_utc", utc_bcd, 24'h235959);
    check_eq("a2_lock", gps_lock, 1);

    // Wrong checksum
    snap();
    send_str("$GPRMC,123519,A,4807.038,N,01131.000,E,022.4,084.4,230394,003.1,W*6B\r\n");
    settle();
`ifdef GPS_NMEA_CHECKSUM_EN
    check_eq("badchk_err_count", n_err - e0, 1);
    check_eq("badchk_commit_count", n_valid - v0, 0);
    check_eq("badchk_utc", utc_bcd, 24'h235959);
`else
    check_eq("badchk_err_count", n_err - e0, 0);
    check_eq("badchk_commit_count", n_valid - v0, 1);
    check_eq("badchk_utc", utc_bcd, 24'h123519);
`endif
    check_eq("badchk_lock", gps_lock, 1);

    // Framing error, then a good sentence
    snap();
    send_byte(8'h00, 1'b0);
    settle();
    check_eq("frame_err_count", n_err - e0, 1);
    check_eq("frame_commit_count", n_valid - v0, 0);
    snap();
    send_sentence("GPRMC,010203,A,4807.038,N,01131.000,E,022.4,084.4,230394,003.1,W", 8'h00);
    settle();
    check_eq("after_frame_commit", n_valid - v0, 1);
    check_eq("after_frame_utc", utc_bcd, 24'h010203);

    // Non-RMC header is ignored silently
    snap();
    send_sentence("GPGGA,111111,A,4807.038,N,01131.000,E", 8'h00);
    settle();
    check_eq("gga_commit_count", n_valid - v0, 0);
    check_eq("gga_err_count", n_err - e0, 0);
    check_eq("gga_utc", utc_bcd, 24'h010203);

    // '$' mid-sentence restarts without error
    snap();
    send_str("$GPRMC,0911");
    send_sentence("GPRMC,101010,A,4807.038,N,01131.000,E,022.4,084.4,230394,003.1,W", 8'h00);
    settle();
    check_eq("restart_commit_count", n_valid - v0, 1);
    check_eq("restart_err_count", n_err - e0, 0);
    check_eq("restart_utc", utc_bcd, 24'h101010);

    // Exactly 82 characters commits
    body = "GPRMC,121212,A,";
    for (int i = 0; i < 63; i++) body = {body, "X"};
    snap();
    send_sentence(body, 8'h00);
    settle();
    check_eq("len82_commit_count", n_valid - v0, 1);
    check_eq("len82_err_count", n_err - e0, 0);
    check_eq("len82_utc", utc_bcd, 24'h121212);

    // 83 characters is overlong
    body = "GPRMC,131313,A,";
    for (int i = 0; i < 64; i++) body = {body, "X"};
    snap();
    send_sentence(body, 8'h00);
    settle();
    check_eq("len83_err_count", n_err - e0, 1);
    check_eq("len83_commit_count", n_valid - v0, 0);
    check_eq("len83_utc", utc_bcd, 24'h121212);
    check_eq("pre_timeout_lock", gps_lock, 1);

    // Silence: lock falls exactly LOCK_TICKS cycles after the last commit
    for (int k = 0; (k < 2 * LOCK_TICKS) && (gps_lock !== 1'b0); k++) @(negedge clk);
    repeat (2) @(negedge clk);
    check_eq("timeout_lock", gps_lock, 0);
    check_eq("timeout_cycles", t_fall - t_commit, LOCK_TICKS);

    // Reset mid-sentence clears everything and discards partial data
    send_sentence("GPRMC,202020,A,4807.038,N,01131.000,E,022.4,084.4,230394,003.1,W", 8'h00);
    settle();
    check_eq("prereset_lock", gps_lock, 1);
    check_eq("prereset_utc", utc_bcd, 24'h202020);
    send_str("$GPRMC,2120");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("midreset_lock", gps_lock, 0);
    check_eq("midreset_utc", utc_bcd, 24'h000000);
    check_eq("midreset_rmc_valid", rmc_valid, 0);
    check_eq("midreset_rx_err", rx_err, 0);
    snap();
    send_str("21,A,4807.038,N*00\r\n");
    settle();
    check_eq("postreset_commit_count", n_valid - v0, 0);
    check_eq("postreset_utc", utc_bcd, 24'h000000);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
